// File: rtl/pwm_pkg.sv
// Shared PWM definitions: sequencer states, mode codes and default field width.
package pwm_pkg;

  localparam int unsigned PWM_W      = 32;
  localparam int unsigned PWM_MODE_W = 32;

  localparam logic [PWM_MODE_W-1:0] PWM_MODE_OFF    = 32'd0;
  localparam logic [PWM_MODE_W-1:0] PWM_MODE_EDGE   = 32'd1;
  localparam logic [PWM_MODE_W-1:0] PWM_MODE_CENTER = 32'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/pwm_period_tick.sv
// Period counter: registered one-cycle tick at the end of every PWM period while enabled.
module pwm_period_tick #(
  parameter int unsigned W = 32
) (
  input  logic         I_SYS_CLK,
  input  logic         I_RST_N,
  input  logic         I_EN,
  input  logic [W-1:0] I_DIV,
  output logic         O_TICK
);

  logic [W-1:0] r_pcnt;
  logic [W-1:0] w_last;

  // Divider of 0 or 1 collapses the period to a single clock.
  assign w_last = (I_DIV <= W'(1)) ? '0 : I_DIV - W'(1);

  // Count 0..P-1; the counter is held at zero whenever disabled.
  always_ff @(posedge I_SYS_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      r_pcnt <= '0;
      O_TICK <= 1'b0;
    end else if (!I_EN) begin
      r_pcnt <= '0;
      O_TICK <= 1'b0;
    end else if (r_pcnt >= w_last) begin
      r_pcnt <= '0;
      O_TICK <= 1'b1;
    end else begin
      r_pcnt <= r_pcnt + W'(1);
      O_TICK <= 1'b0;
    end
  end

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Ramps pwm_module's duty toward a target in fixed steps on period boundaries.
module pwm_duty_sequencer
  import pwm_pkg::*;
#(
  parameter int unsigned W = PWM_W
) (
  input  logic                  I_SYS_CLK,
  input  logic                  I_RST_N,
  input  logic                  I_START,
  input  logic                  I_ABORT,
  input  logic [PWM_MODE_W-1:0] I_CFG_MODE,
  input  logic [W-1:0]          I_CFG_FREQ_DIV,
  input  logic [W-1:0]          I_CFG_TARGET,
  input  logic [W-1:0]          I_CFG_STEP,
  input  logic [W-1:0]          I_CFG_HOLD,
  output logic [PWM_MODE_W-1:0] O_PWM_MODE,
  output logic [W-1:0]          O_PWM_FREQ_DIV,
  output logic [W-1:0]          O_PWM_DUTY,
  output logic                  O_BUSY,
  output logic                  O_DONE
);

  seq_state_t            r_state, w_state_nxt;
  logic [W-1:0]          r_tgt, r_step, r_hold, r_hcnt;
  logic [W-1:0]          w_tgt_nxt, w_step_nxt, w_hold_nxt, w_hcnt_nxt;
  logic [PWM_MODE_W-1:0] w_mode_nxt;
  logic [W-1:0]          w_div_nxt, w_duty_nxt;
  logic                  w_busy_nxt, w_done_nxt;

  logic                  w_tick;
  logic [W-1:0]          w_cfg_tgt, w_step_eff, w_hold_eff, w_step_duty;
  logic [W:0]            w_diff;
  logic                  w_up, w_last, w_hold_hit;

  // Period boundary source, running only while ramping.
  pwm_period_tick #(.W(W)) u_tick (
    .I_SYS_CLK (I_SYS_CLK),
    .I_RST_N   (I_RST_N),
    .I_EN      (r_state == ST_RAMP),
    .I_DIV     (O_PWM_FREQ_DIV),
    .O_TICK    (w_tick)
  );

  // Step/clamp arithmetic; the difference is one bit wider so it cannot wrap.
  assign w_cfg_tgt   = (I_CFG_TARGET > I_CFG_FREQ_DIV) ? I_CFG_FREQ_DIV : I_CFG_TARGET;
  assign w_step_eff  = (r_step == '0) ? W'(1) : r_step;
  assign w_hold_eff  = (r_hold == '0) ? W'(1) : r_hold;
  assign w_up        = (r_tgt >= O_PWM_DUTY);
  assign w_diff      = w_up ? ({1'b0, r_tgt} - {1'b0, O_PWM_DUTY})
                            : ({1'b0, O_PWM_DUTY} - {1'b0, r_tgt});
  assign w_last      = (w_diff <= {1'b0, w_step_eff});
  assign w_step_duty = w_up ? O_PWM_DUTY + w_step_eff : O_PWM_DUTY - w_step_eff;
  assign w_hold_hit  = (r_hcnt >= w_hold_eff - W'(1));

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = O_PWM_MODE;
    w_div_nxt   = O_PWM_FREQ_DIV;
    w_duty_nxt  = O_PWM_DUTY;
    w_tgt_nxt   = r_tgt;
    w_step_nxt  = r_step;
    w_hold_nxt  = r_hold;
    w_hcnt_nxt  = r_hcnt;
    w_done_nxt  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (I_START && !I_ABORT) begin
          w_mode_nxt  = I_CFG_MODE;
          w_div_nxt   = I_CFG_FREQ_DIV;
          w_tgt_nxt   = w_cfg_tgt;
          w_step_nxt  = I_CFG_STEP;
          w_hold_nxt  = I_CFG_HOLD;
          w_hcnt_nxt  = '0;
          w_state_nxt = (w_cfg_tgt == O_PWM_DUTY) ? ST_DONE : ST_RAMP;
        end
      end
      ST_RAMP: begin
        if (I_ABORT) begin
          w_state_nxt = ST_IDLE;
          w_hcnt_nxt  = '0;
        end else if (w_tick) begin
          if (w_hold_hit) begin
            w_hcnt_nxt = '0;
            if (w_last) begin
              w_duty_nxt  = r_tgt;
              w_state_nxt = ST_DONE;
            end else begin
              w_duty_nxt = w_step_duty;
            end
          end else begin
            w_hcnt_nxt = r_hcnt + W'(1);
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_done_nxt  = !I_ABORT;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt == ST_RAMP);
  end

  // State, configuration and output registers.
  always_ff @(posedge I_SYS_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      r_state        <= ST_IDLE;
      r_tgt          <= '0;
      r_step         <= '0;
      r_hold         <= '0;
      r_hcnt         <= '0;
      O_PWM_MODE     <= '0;
      O_PWM_FREQ_DIV <= '0;
      O_PWM_DUTY     <= '0;
      O_BUSY         <= 1'b0;
      O_DONE         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_tgt          <= w_tgt_nxt;
      r_step         <= w_step_nxt;
      r_hold         <= w_hold_nxt;
      r_hcnt         <= w_hcnt_nxt;
      O_PWM_MODE     <= w_mode_nxt;
      O_PWM_FREQ_DIV <= w_div_nxt;
      O_PWM_DUTY     <= w_duty_nxt;
      O_BUSY         <= w_busy_nxt;
      O_DONE         <= w_done_nxt;
    end
  end

endmodule
